tactile_scan_sequencer: RTL and testbench
=========================================

Name: tactile_scan_sequencer

Overview:
- Master timing generator for the tactile grid scan.
- Drives the step pulses consumed by the switch and read mux selector counters.
- Sequences settle delay and ADC conversion handshake, and emits one tagged sample per grid crossing.
- Sits between the top-level control (start/continuous) and the ADC front end; its pulse outputs feed the mux selector directly.

Parameters:
SW_WIRE_CNT, 16, number of drive (switch) wires; must be >= 2
RD_WIRE_CNT, 16, number of sense (read) wires; must be >= 2
SETTLE_CYCLES, 100, clk_in cycles to wait after a mux change before starting conversion; must be >= 1
ADC_W, 12, ADC sample width

Ports:
clk_in  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a frame; honoured only in IDLE
continuous  input  1  when 1 at frame end, the next frame starts immediately
adc_done  input  1  single-cycle conversion-complete strobe from ADC
adc_data  input  ADC_W  conversion result, valid when adc_done=1
adc_start  output  1  single-cycle conversion request
pulse_sw  output  1  single-cycle step of the switch mux selector
pulse_rd  output  1  single-cycle step of the read mux selector
sample_valid  output  1  single-cycle sample strobe
sample_data  output  ADC_W  sample value, valid with sample_valid
sample_sw  output  $clog2(SW_WIRE_CNT)  switch index of the sample
sample_rd  output  $clog2(RD_WIRE_CNT)  read index of the sample
busy  output  1  1 in any state other than IDLE
frame_done  output  1  single-cycle strobe on the last sample of a frame

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - Internal sw_idx, rd_idx and settle counter are cleared.
  - All outputs are 0.
  - rst must also drive the mux selector's reset so both sides restart at index 0.
- Outputs are registered, and every strobe is exactly one cycle wide.
- States:
  - IDLE: start=1 -> SETTLE, with the counter loaded to SETTLE_CYCLES-1.
  - SETTLE: decrement each cycle. At 0 -> CONV. Total dwell is exactly SETTLE_CYCLES cycles.
  - CONV: adc_start=1 for this one cycle -> WAIT.
  - WAIT: hold until adc_done=1. Latch adc_data -> EMIT.
  - EMIT: one cycle with:
    - sample_valid=1.
    - sample_data = latched value.
    - sample_sw/sample_rd = current indices.
    - pulse_rd=1.
    - If rd_idx==RD_WIRE_CNT-1, also pulse_sw=1 in the same cycle.
- Index update, on leaving EMIT:
  - rd_idx wraps RD_WIRE_CNT-1 -> 0; otherwise it increments.
  - sw_idx increments only when rd_idx wraps, and wraps SW_WIRE_CNT-1 -> 0.
- Frame end, when EMIT has sw_idx==SW_WIRE_CNT-1 and rd_idx==RD_WIRE_CNT-1:
  - frame_done=1 in the same cycle as that sample_valid.
  - Next state is SETTLE if continuous=1 that cycle, otherwise IDLE.
- Otherwise EMIT -> SETTLE.
- Lockstep invariant: per frame, exactly SW_WIRE_CNT*RD_WIRE_CNT pulse_rd and exactly SW_WIRE_CNT pulse_sw are issued. The downstream selector therefore returns to 0/0 at frame end.
- Sample period: SETTLE_CYCLES + 1 (CONV) + ADC latency + 1 (EMIT) cycles. ADC latency is counted from the adc_start cycle to the adc_done cycle, minimum 1.
- Boundary conditions:
  - start while busy: ignored.
  - adc_done outside WAIT: ignored and not latched.
  - adc_done in the same cycle as adc_start: ignored, because it is not yet in WAIT.
  - continuous dropping mid-frame: the current frame completes, then the block goes to IDLE.
  - start and continuous both 1 in IDLE: normal start.
  - rst mid-frame: immediate abort. No further strobes are issued and no partial-frame frame_done is produced.
- Width rules:
  - Index registers are exactly $clog2 of their count.
  - Compares against CNT-1 are done at that width.
  - No overflow-based wrap.

Decomposition:
- Package tactile_pkg holds:
  - the state enum scan_state_t {IDLE, SETTLE, CONV, WAIT, EMIT};
  - the default wire counts and ADC_W constant, shared with the mux selector.
- One natural sub-module: scan_index_counter. It is the rd/sw nested wrap counter with inputs advance and clear, and outputs the indices, rd_last and frame_last.
- FSM and settle timer stay in the top module.

Test Plan:
- 2x2 grid, SETTLE_CYCLES=3, ADC responds 2 cycles after adc_start with data=0x100+n, single start -> 4 samples:
  - (sw,rd) = (0,0),(0,1),(1,0),(1,1), data 0x100..0x103;
  - pulse_rd x4, pulse_sw x2 (at samples 2 and 4);
  - frame_done with the 4th sample;
  - period 7 cycles; busy then drops.
- Settle timing, SETTLE_CYCLES=1 -> adc_start occurs exactly 2 cycles after the start cycle (1 cycle SETTLE + CONV).
- ADC stall: hold adc_done low 50 cycles -> no sample_valid and no pulses during the stall; spurious adc_done pulses in SETTLE are not reported as samples.
- continuous=1 on the 3x2 grid -> the second frame begins without a start. After two frames, a modelled mux selector reads 0/0 and frame_done fires twice.
- start asserted while busy -> no effect on the sample count or order.
- Async rst asserted mid-WAIT -> all outputs 0 in the same cycle. A following start yields (0,0) as the first sample.

Source files
------------

// File: rtl/tactile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tactile_pkg
// Brief   : Shared scan-state encoding and grid/ADC defaults for the tactile
//           scan sequencer and the mux selector.
// Rev     : 1.0
// ============================================================================
package tactile_pkg;

    localparam int C_SW_WIRE_CNT_DEF = 16;
    localparam int C_RD_WIRE_CNT_DEF = 16;
    localparam int C_ADC_W_DEF       = 12;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        CONV   = 3'd2,
        WAIT   = 3'd3,
        EMIT   = 3'd4
    } scan_state_t;

endpackage : tactile_pkg
`default_nettype wire

// File: rtl/tactile_scan_sequencer_index.sv
`default_nettype none
// ============================================================================
// Module  : scan_index_counter
// Brief   : Nested read/switch wire index counter with frame-end flags.
// Rev     : 1.0
// ============================================================================
module scan_index_counter
    import tactile_pkg::*;
#(
    parameter int   SW_WIRE_CNT = C_SW_WIRE_CNT_DEF,
    parameter int   RD_WIRE_CNT = C_RD_WIRE_CNT_DEF,
    localparam int  SW_W        = $clog2(SW_WIRE_CNT),
    localparam int  RD_W        = $clog2(RD_WIRE_CNT)
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic            advance_i,
    input  logic            clear_i,
    output logic [SW_W-1:0] sw_idx_o,
    output logic [RD_W-1:0] rd_idx_o,
    output logic            rd_last_o,
    output logic            frame_last_o
);

    localparam logic [SW_W-1:0] C_SW_LAST = SW_W'(SW_WIRE_CNT - 1);
    localparam logic [RD_W-1:0] C_RD_LAST = RD_W'(RD_WIRE_CNT - 1);

    logic [SW_W-1:0] sw_idx_q, sw_idx_d;
    logic [RD_W-1:0] rd_idx_q, rd_idx_d;

    // Explicit compare-and-wrap so non-power-of-two counts never rely on overflow.
    always_comb begin
        sw_idx_d = sw_idx_q;
        rd_idx_d = rd_idx_q;
        if (clear_i) begin
            sw_idx_d = '0;
            rd_idx_d = '0;
        end else if (advance_i) begin
            if (rd_idx_q == C_RD_LAST) begin
                rd_idx_d = '0;
                sw_idx_d = (sw_idx_q == C_SW_LAST) ? '0 : sw_idx_q + 1'b1;
            end else begin
                rd_idx_d = rd_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sw_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            sw_idx_q <= sw_idx_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    assign sw_idx_o     = sw_idx_q;
    assign rd_idx_o     = rd_idx_q;
    assign rd_last_o    = (rd_idx_q == C_RD_LAST);
    assign frame_last_o = (rd_idx_q == C_RD_LAST) && (sw_idx_q == C_SW_LAST);

endmodule : scan_index_counter
`default_nettype wire

// File: rtl/tactile_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tactile_scan_sequencer
// Brief   : Grid scan timing master: settle, ADC handshake, tagged samples and
//           mux selector step pulses.
// Rev     : 1.0
// ============================================================================
module tactile_scan_sequencer
    import tactile_pkg::*;
#(
    parameter int   SW_WIRE_CNT   = C_SW_WIRE_CNT_DEF,
    parameter int   RD_WIRE_CNT   = C_RD_WIRE_CNT_DEF,
    parameter int   SETTLE_CYCLES = 100,
    parameter int   ADC_W         = C_ADC_W_DEF,
    localparam int  SW_W          = $clog2(SW_WIRE_CNT),
    localparam int  RD_W          = $clog2(RD_WIRE_CNT)
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_data,
    output logic             adc_start,
    output logic             pulse_sw,
    output logic             pulse_rd,
    output logic             sample_valid,
    output logic [ADC_W-1:0] sample_data,
    output logic [SW_W-1:0]  sample_sw,
    output logic [RD_W-1:0]  sample_rd,
    output logic             busy,
    output logic             frame_done
);

    localparam int              C_CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_SETTLE_LOAD = C_CNT_W'(SETTLE_CYCLES - 1);

    scan_state_t         state_q;
    logic [C_CNT_W-1:0]  settle_q;
    logic                adc_start_q;
    logic                pulse_sw_q;
    logic                pulse_rd_q;
    logic                sample_valid_q;
    logic [ADC_W-1:0]    sample_data_q;
    logic [SW_W-1:0]     sample_sw_q;
    logic [RD_W-1:0]     sample_rd_q;
    logic                busy_q;
    logic                frame_done_q;

    logic [SW_W-1:0]     sw_idx;
    logic [RD_W-1:0]     rd_idx;
    logic                rd_last;
    logic                frame_last;

    scan_index_counter #(
        .SW_WIRE_CNT (SW_WIRE_CNT),
        .RD_WIRE_CNT (RD_WIRE_CNT)
    ) u_index (
        .clk_in       (clk_in),
        .rst          (rst),
        .advance_i    (state_q == EMIT),
        .clear_i      ((state_q == IDLE) && start),
        .sw_idx_o     (sw_idx),
        .rd_idx_o     (rd_idx),
        .rd_last_o    (rd_last),
        .frame_last_o (frame_last)
    );

    // Strobes are set on the edge that enters their state so they line up with it.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            settle_q       <= '0;
            adc_start_q    <= 1'b0;
            pulse_sw_q     <= 1'b0;
            pulse_rd_q     <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_data_q  <= '0;
            sample_sw_q    <= '0;
            sample_rd_q    <= '0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            adc_start_q    <= 1'b0;
            pulse_sw_q     <= 1'b0;
            pulse_rd_q     <= 1'b0;
            sample_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= SETTLE;
                        settle_q <= C_SETTLE_LOAD;
                        busy_q   <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_q == '0) begin
                        state_q     <= CONV;
                        adc_start_q <= 1'b1;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                CONV: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (adc_done) begin
                        state_q        <= EMIT;
                        sample_valid_q <= 1'b1;
                        sample_data_q  <= adc_data;
                        sample_sw_q    <= sw_idx;
                        sample_rd_q    <= rd_idx;
                        pulse_rd_q     <= 1'b1;
                        pulse_sw_q     <= rd_last;
                        frame_done_q   <= frame_last;
                    end
                end
                EMIT: begin
                    if (frame_last && !continuous) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q  <= SETTLE;
                        settle_q <= C_SETTLE_LOAD;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign adc_start    = adc_start_q;
    assign pulse_sw     = pulse_sw_q;
    assign pulse_rd     = pulse_rd_q;
    assign sample_valid = sample_valid_q;
    assign sample_data  = sample_data_q;
    assign sample_sw    = sample_sw_q;
    assign sample_rd    = sample_rd_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;

endmodule : tactile_scan_sequencer
`default_nettype wire

// File: tb/tb_tactile_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_tactile_scan_sequencer
// Brief   : Self-checking bench: 3x2 grid scan with ADC responder, scoreboard
//           and mux selector model; second 2x2 instance for settle timing.
// Rev     : 1.0
// ============================================================================
module tb_tactile_scan_sequencer;

    localparam int SW  = 3;
    localparam int RD  = 2;
    localparam int ST  = 3;
    localparam int AW  = 12;
    localparam int NPF = SW * RD;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, continuous, adc_done;
    logic [AW-1:0] adc_data;
    logic          adc_start, pulse_sw, pulse_rd, sample_valid, busy, frame_done;
    logic [AW-1:0] sample_data;
    logic [1:0]    sample_sw;
    logic [0:0]    sample_rd;

    logic          start1, cont1, adc_done1;
    logic [AW-1:0] adc_data1;
    logic          adc_start1, pulse_sw1, pulse_rd1, sample_valid1, busy1, frame_done1;
    logic [AW-1:0] sample_data1;
    logic [0:0]    sample_sw1, sample_rd1;

    always #5 clk = ~clk;

    tactile_scan_sequencer #(
        .SW_WIRE_CNT(SW), .RD_WIRE_CNT(RD), .SETTLE_CYCLES(ST), .ADC_W(AW)
    ) u_dut (
        .clk_in(clk), .rst(rst), .start(start), .continuous(continuous),
        .adc_done(adc_done), .adc_data(adc_data), .adc_start(adc_start),
        .pulse_sw(pulse_sw), .pulse_rd(pulse_rd), .sample_valid(sample_valid),
        .sample_data(sample_data), .sample_sw(sample_sw), .sample_rd(sample_rd),
        .busy(busy), .frame_done(frame_done)
    );

    tactile_scan_sequencer #(
        .SW_WIRE_CNT(2), .RD_WIRE_CNT(2), .SETTLE_CYCLES(1), .ADC_W(AW)
    ) u_dut1 (
        .clk_in(clk), .rst(rst), .start(start1), .continuous(cont1),
        .adc_done(adc_done1), .adc_data(adc_data1), .adc_start(adc_start1),
        .pulse_sw(pulse_sw1), .pulse_rd(pulse_rd1), .sample_valid(sample_valid1),
        .sample_data(sample_data1), .sample_sw(sample_sw1), .sample_rd(sample_rd1),
        .busy(busy1), .frame_done(frame_done1)
    );

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;

    // Scoreboard / model state
    logic [AW-1:0] exp_q[$];
    int            nsamp     = 0;
    int            frames    = 0;
    int            rd_sel    = 0;
    int            sw_sel    = 0;
    int            last_vcyc = -1;
    bit            chk_period = 1'b0;

    // ADC responder controls
    int            lat       = 2;
    bit            lat_rand  = 1'b0;
    bit            fixed_dat = 1'b1;
    bit            spur      = 1'b0;
    int            conv_n    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ADC front-end model: responds lat cycles after adc_start, optionally
    // injecting junk strobes in the adc_start cycle and in the settle cycle.
    initial begin
        int cd;
        bit pend_spur;
        logic [AW-1:0] d;
        cd = -1;
        pend_spur = 1'b0;
        adc_done = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clk);
            adc_done = 1'b0;
            if (rst) begin
                cd = -1;
                pend_spur = 1'b0;
            end else begin
                if (pend_spur) begin
                    adc_done  = 1'b1;
                    adc_data  = 12'hBAD;
                    pend_spur = 1'b0;
                end
                if (adc_start) begin
                    cd = lat_rand ? int'($urandom_range(1, 4)) : lat;
                    if (spur) begin
                        adc_done = 1'b1;
                        adc_data = 12'hBAD;
                    end
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        d = fixed_dat ? AW'(32'h100 + conv_n) : AW'($urandom);
                        conv_n++;
                        adc_done = 1'b1;
                        adc_data = d;
                        exp_q.push_back(d);
                        cd = -1;
                    end
                end
                if (sample_valid && spur) pend_spur = 1'b1;
            end
        end
    end

    // Sample monitor: expected tags come from the sample ordinal in the frame.
    initial begin
        int k;
        logic [AW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sample_valid) begin
                    k = nsamp % NPF;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                    chk("sample_data", 32'(sample_data), 32'(e));
                    chk("sample_sw", 32'(sample_sw), k / RD);
                    chk("sample_rd", 32'(sample_rd), k % RD);
                    chk("pulse_rd", 32'(pulse_rd), 1);
                    chk("pulse_sw", 32'(pulse_sw), ((k % RD) == RD - 1) ? 1 : 0);
                    chk("frame_done", 32'(frame_done), (k == NPF - 1) ? 1 : 0);
                    if (chk_period && k != 0 && last_vcyc >= 0)
                        chk("period", cyc - last_vcyc, ST + 1 + 2 + 1);
                    last_vcyc = cyc;
                    if (frame_done) frames++;
                    nsamp++;
                end else begin
                    chk("quiet_strobes", {29'd0, pulse_rd, pulse_sw, frame_done}, 0);
                end
                if (pulse_rd) rd_sel = (rd_sel + 1) % RD;
                if (pulse_sw) sw_sel = (sw_sel + 1) % SW;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy), 0);
    endtask

    task automatic wait_astart(input int maxc);
        int n;
        n = 0;
        while (!adc_start && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("adc_start_timeout", 32'(adc_start), 1);
    endtask

    task automatic wait_nsamp(input int target, input int maxc);
        int n;
        n = 0;
        while (nsamp < target && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("sample_timeout", nsamp >= target, 1);
    endtask

    initial begin
        int base_s, base_f;
        rst = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        start1 = 1'b0;
        cont1 = 1'b0;
        adc_done1 = 1'b0;
        adc_data1 = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {adc_start, pulse_sw, pulse_rd, sample_valid, busy,
                              frame_done, sample_sw, sample_rd, sample_data}, 0);
        rst = 1'b0;

        // Single frame, fixed latency and data 0x100+n, period check
        chk_period = 1'b1;
        pulse_start();
        chk("busy_after_start", 32'(busy), 1);
        wait_idle(200);
        chk_period = 1'b0;
        chk("f1_samples", nsamp, NPF);
        chk("f1_frames", frames, 1);
        chk("f1_mux_sel", {sw_sel[15:0], rd_sel[15:0]}, 0);

        // Settle timing on the SETTLE_CYCLES=1 instance
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("st1_busy", 32'(busy1), 1);
        chk("st1_no_early_astart", 32'(adc_start1), 0);
        @(negedge clk);
        chk("st1_astart_at_2", 32'(adc_start1), 1);

        // Random data/latency, junk strobes, ADC stall, start while busy
        fixed_dat = 1'b0;
        lat_rand  = 1'b1;
        spur      = 1'b1;
        base_s    = nsamp;
        pulse_start();
        wait_nsamp(base_s + 2, 200);
        lat_rand = 1'b0;
        lat      = 60;
        wait_astart(100);
        @(negedge clk);
        lat_rand = 1'b1;
        chk("stall_count_begin", nsamp, base_s + 2);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (44) @(negedge clk);
        chk("stall_no_samples", nsamp, base_s + 2);
        chk("stall_busy", 32'(busy), 1);
        wait_idle(600);
        chk("f2_samples", nsamp, base_s + NPF);
        chk("f2_frames", frames, 2);
        repeat (30) @(negedge clk);
        chk("no_extra_frame", nsamp, base_s + NPF);
        chk("f2_mux_sel", {sw_sel[15:0], rd_sel[15:0]}, 0);

        // Continuous: second frame starts by itself; drop continuous mid-frame
        base_s = nsamp;
        base_f = frames;
        continuous = 1'b1;
        pulse_start();
        wait_nsamp(base_s + NPF + 2, 400);
        continuous = 1'b0;
        wait_idle(400);
        chk("cont_samples", nsamp, base_s + 2 * NPF);
        chk("cont_frames", frames, base_f + 2);
        chk("cont_mux_sel", {sw_sel[15:0], rd_sel[15:0]}, 0);

        // Async reset while waiting on the ADC, then a clean frame
        spur     = 1'b0;
        lat_rand = 1'b0;
        lat      = 2;
        base_s   = nsamp;
        base_f   = frames;
        pulse_start();
        wait_nsamp(base_s + 3, 200);
        lat = 60;
        wait_astart(100);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs", {adc_start, pulse_sw, pulse_rd, sample_valid, busy,
                                  frame_done, sample_sw, sample_rd, sample_data}, 0);
        @(negedge clk);
        exp_q.delete();
        nsamp  = 0;
        rd_sel = 0;
        sw_sel = 0;
        chk("abort_no_frame_done", frames, base_f);
        rst = 1'b0;
        lat = 2;
        lat_rand = 1'b1;
        pulse_start();
        wait_idle(300);
        chk("post_rst_samples", nsamp, NPF);
        chk("post_rst_frames", frames, base_f + 1);
        chk("post_rst_mux_sel", {sw_sel[15:0], rd_sel[15:0]}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tactile_scan_sequencer
`default_nettype wire
